// File: rtl/pending_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pending_enc_pkg
// Brief    : Shared types and helpers for the pending-request priority encoder
// Revision : 1.0 - initial release
// ============================================================================
package pending_enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int DEFAULT_N = 4;

  // Highest set bit index of a vector of up to 32 bits; 0 when empty.
  function automatic logic [4:0] msb_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_msb_find.sv
`default_nettype none
// ============================================================================
// Module   : prio_msb_find
// Brief    : Combinational highest-set-bit finder with a found flag
// Revision : 1.0 - initial release
// ============================================================================
module prio_msb_find
  import pending_enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  assign o_idx   = W'(msb_index(32'(i_vec)));
  assign o_found = |i_vec;

endmodule
`default_nettype wire

// File: rtl/pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pending_priority_encoder
// Brief    : Sticky request collector serving the highest pending index over
//            a valid/ready handshake
// Revision : 1.0 - initial release
// ============================================================================
module pending_priority_encoder
  import pending_enc_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         any_pending,
  output logic         overflow
);

  state_t         r_state;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   r_out_code;
  logic           r_overflow;

  logic [W-1:0]   w_idx;
  logic           w_found;
  logic           w_accept;
  logic           w_issue;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_capture;

  prio_msb_find #(
    .N (N),
    .W (W)
  ) u_msb (
    .i_vec   (r_pending),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_accept  = (r_state == PRESENT) && out_ready;
  assign w_issue   = en && w_found && ((r_state == IDLE) || w_accept);
  assign w_clr     = w_issue ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_capture = en ? req : '0;

  // A request landing on its own issue cycle re-arms the bit without overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_out_code <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_clr) | w_capture;
      r_overflow <= |(w_capture & r_pending & ~w_clr);
      if (w_issue) begin
        r_out_code <= w_idx;
        r_state    <= PRESENT;
      end else if (w_accept) begin
        r_state    <= IDLE;
      end
    end
  end

  assign out_valid   = (r_state == PRESENT);
  assign out_code    = r_out_code;
  assign any_pending = |r_pending;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pending_priority_encoder
// Brief    : Directed self-checking bench with a per-cycle reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pending_priority_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         any_pending;
  logic         overflow;

  int total;
  int bad;

  pending_priority_encoder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .any_pending (any_pending),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a set of pending indices, one served slot, overflow flag.
  bit         m_pend [N];
  bit         m_valid;
  int         m_code;
  bit         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    int  hi;
    bit  acc;
    bit  iss;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_code  = 0;
      m_ovf   = 1'b0;
    end else begin
      hi = -1;
      for (int i = N - 1; i >= 0; i--) if (hi < 0 && m_pend[i]) hi = i;
      acc = m_valid && out_ready;
      iss = en && (hi >= 0) && (!m_valid || acc);
      if (iss) m_pend[hi] = 1'b0;
      m_ovf = 1'b0;
      if (en) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && m_pend[i]) m_ovf = 1'b1;
          if (req[i]) m_pend[i] = 1'b1;
        end
      end
      if (iss) begin
        m_valid = 1'b1;
        m_code  = hi;
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_any();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a = a | m_pend[i];
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_any_pending", 32'(any_pending), 32'(model_any()));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) chk("model_code", 32'(out_code), 32'(m_code));
    end
  end

  // Apply inputs, let one rising edge pass, return just after it.
  task automatic drive(input logic e, input logic [N-1:0] r, input logic rd);
    en        = e;
    req       = r;
    out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input int code,
                            input logic ap, input logic ovf);
    chk({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({name, "_code"}, 32'(out_code), 32'(code));
    chk({name, "_any"}, 32'(any_pending), 32'(ap));
    chk({name, "_ovf"}, 32'(overflow), 32'(ovf));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_code", 32'(out_code), 32'd0);
    chk("reset_any", 32'(any_pending), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic path
    drive(1, 4'b0100, 1);  expect_out("basic_t1", 0, 0, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("basic_t2", 1, 2, 0, 0);
    drive(1, 4'b0000, 1);  expect_out("basic_t3", 0, 0, 0, 0);

    // Priority drain under backpressure
    drive(1, 4'b1011, 0);  expect_out("drain_cap", 0, 0, 1, 0);
    drive(1, 4'b0000, 0);  expect_out("drain_s1", 1, 3, 1, 0);
    drive(1, 4'b0000, 0);  expect_out("drain_s2", 1, 3, 1, 0);
    drive(1, 4'b0000, 0);  expect_out("drain_s3", 1, 3, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("drain_c1", 1, 1, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("drain_c0", 1, 0, 0, 0);
    drive(1, 4'b0000, 1);  expect_out("drain_end", 0, 0, 0, 0);

    // Overflow while bit 3 is in flight
    drive(1, 4'b1000, 0);  expect_out("ovf_cap3", 0, 0, 1, 0);
    drive(1, 4'b0001, 0);  expect_out("ovf_first", 1, 3, 1, 0);
    drive(1, 4'b0001, 0);  expect_out("ovf_second", 1, 3, 1, 1);
    drive(1, 4'b0000, 0);  expect_out("ovf_drop", 1, 3, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("ovf_serve0", 1, 0, 0, 0);
    drive(1, 4'b0000, 1);  expect_out("ovf_end", 0, 0, 0, 0);

    // Re-request on the issue cycle
    drive(1, 4'b1000, 1);  expect_out("rereq_cap", 0, 0, 1, 0);
    drive(1, 4'b1000, 0);  expect_out("rereq_issue", 1, 3, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("rereq_again", 1, 3, 0, 0);
    drive(1, 4'b0000, 1);  expect_out("rereq_end", 0, 0, 0, 0);

    // Enable gating
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'b1111, 1);
      expect_out("en_off", 0, 0, 0, 0);
    end
    drive(1, 4'b0110, 0);  expect_out("en_cap", 0, 0, 1, 0);
    drive(1, 4'b0000, 0);  expect_out("en_issue", 1, 2, 1, 0);
    drive(0, 4'b0000, 1);  expect_out("en_accept", 0, 0, 1, 0);
    drive(0, 4'b0000, 1);  expect_out("en_frozen", 0, 0, 1, 0);
    drive(1, 4'b0000, 1);  expect_out("en_resume", 1, 1, 0, 0);
    drive(1, 4'b0000, 1);  expect_out("en_end", 0, 0, 0, 0);

    // Reset mid-operation
    drive(1, 4'b1110, 0);  expect_out("rst_cap", 0, 0, 1, 0);
    drive(1, 4'b0000, 0);  expect_out("rst_pre", 1, 3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_code", 32'(out_code), 32'd0);
    chk("rst_async_any", 32'(any_pending), 32'd0);
    chk("rst_async_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'b0000, 1);
      expect_out("rst_after", 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
